shift_sequencer: RTL and testbench

- Multi-bit shift controller that sequences the team's single-bit shifter datapath.
- Accepts a request: operand, signed shift amount and shift type.
- Drives the shifter one bit per cycle and feeds its output back as the next operand.
- Returns the final result with a one-cycle done pulse.
- Sits between the ALU decode/control logic and the shifter instance; the shifter itself stays unchanged.

---
 rtl/shift_sequencer.sv | 155 +++++++++++++++
 tb/tb_shift_sequencer.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/shift_sequencer.sv
// Sequences a single-bit shifter to perform signed-amount multi-bit shifts.
// Optional macro SHIFT_EARLY_EXIT_EN ends a run early once the accumulator reaches a fixed point.
module shift_sequencer #(
    parameter int WIDTH = 16,
    parameter int AMT_W = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] src,
    input  logic [AMT_W-1:0] amount,
    input  logic             shift_type,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] sh_src,
    output logic [WIDTH-1:0] sh_dir,
    output logic             sh_type,
`ifdef SHIFT_EARLY_EXIT_EN
    output logic             early_exit,
`endif
    input  logic [WIDTH-1:0] sh_out
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [WIDTH-1:0] DIR_RIGHT = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] DIR_LEFT  = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] DIR_NONE  = {WIDTH{1'b0}};
    localparam logic [AMT_W:0]   CNT_ONE   = {{AMT_W{1'b0}}, 1'b1};

    state_t           r_state;
    logic [WIDTH-1:0] r_acc;
    logic [AMT_W:0]   r_cnt;
    logic             r_dir;
    logic             r_type;
    logic             r_busy;
    logic             r_done;
    logic [WIDTH-1:0] r_result;
    logic [WIDTH-1:0] r_sh_dir;
    logic [AMT_W:0]   w_amt_ext;
    logic [AMT_W:0]   w_mag;
`ifdef SHIFT_EARLY_EXIT_EN
    logic             r_early_exit;
    logic             w_fixed;
`endif

    // Magnitude is one bit wider so the most negative amount is representable.
    assign w_amt_ext = {amount[AMT_W-1], amount};
    assign w_mag     = amount[AMT_W-1] ? (~w_amt_ext + CNT_ONE) : w_amt_ext;

`ifdef SHIFT_EARLY_EXIT_EN
    // Zero is fixed for every direction; all-ones only for arithmetic right.
    always_comb begin
        w_fixed = 1'b0;
        if (r_acc == {WIDTH{1'b0}}) begin
            w_fixed = 1'b1;
        end else if ((r_acc == {WIDTH{1'b1}}) && r_dir && !r_type) begin
            w_fixed = 1'b1;
        end else begin
            w_fixed = 1'b0;
        end
    end
`endif

    // Control FSM with registered status and shifter-direction outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_acc    <= {WIDTH{1'b0}};
            r_cnt    <= {(AMT_W+1){1'b0}};
            r_dir    <= 1'b0;
            r_type   <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_result <= {WIDTH{1'b0}};
            r_sh_dir <= DIR_NONE;
`ifdef SHIFT_EARLY_EXIT_EN
            r_early_exit <= 1'b0;
`endif
        end else begin
            r_done <= 1'b0;
`ifdef SHIFT_EARLY_EXIT_EN
            r_early_exit <= 1'b0;
`endif
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_acc  <= src;
                        r_type <= shift_type;
                        r_dir  <= amount[AMT_W-1];
                        r_cnt  <= w_mag;
                        r_busy <= 1'b1;
                        if (w_mag == {(AMT_W+1){1'b0}}) begin
                            r_state  <= S_DONE;
                            r_done   <= 1'b1;
                            r_result <= src;
                            r_sh_dir <= DIR_NONE;
                        end else begin
                            r_state  <= S_RUN;
                            r_sh_dir <= amount[AMT_W-1] ? DIR_RIGHT : DIR_LEFT;
                        end
                    end
                end
                S_RUN: begin
`ifdef SHIFT_EARLY_EXIT_EN
                    if (w_fixed) begin
                        r_state      <= S_DONE;
                        r_done       <= 1'b1;
                        r_early_exit <= 1'b1;
                        r_result     <= r_acc;
                        r_sh_dir     <= DIR_NONE;
                    end else begin
`else
                    begin
`endif
                        r_acc <= sh_out;
                        r_cnt <= r_cnt - CNT_ONE;
                        // Result is loaded on entry so it is valid alongside done.
                        if (r_cnt == CNT_ONE) begin
                            r_state  <= S_DONE;
                            r_done   <= 1'b1;
                            r_result <= sh_out;
                            r_sh_dir <= DIR_NONE;
                        end
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state  <= S_IDLE;
                    r_busy   <= 1'b0;
                    r_sh_dir <= DIR_NONE;
                end
            endcase
        end
    end

    assign busy    = r_busy;
    assign done    = r_done;
    assign result  = r_result;
    assign sh_src  = r_acc;
    assign sh_dir  = r_sh_dir;
    assign sh_type = r_type;
`ifdef SHIFT_EARLY_EXIT_EN
    assign early_exit = r_early_exit;
`endif

endmodule

// File: tb/tb_shift_sequencer.sv
// Scoreboard bench for shift_sequencer with a behavioural single-bit shifter model.
module tb_shift_sequencer;

    typedef struct {
        logic [15:0] res;
        int          done_cyc;
        int          busy_cycles;
    } exp_t;

    logic        clk;
    logic        reset;
    logic        start;
    logic [15:0] src;
    logic [4:0]  amount;
    logic        shift_type;
    logic        busy;
    logic        done;
    logic [15:0] result;
    logic [15:0] sh_src;
    logic [15:0] sh_dir;
    logic        sh_type;
    logic [15:0] sh_out;
`ifdef SHIFT_EARLY_EXIT_EN
    logic        early_exit;
`endif

    exp_t sb[$];
    int   cyc;
    int   n_cmp;
    int   n_err;

    shift_sequencer #(.WIDTH(16), .AMT_W(5)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .src        (src),
        .amount     (amount),
        .shift_type (shift_type),
        .busy       (busy),
        .done       (done),
        .result     (result),
        .sh_src     (sh_src),
        .sh_dir     (sh_dir),
        .sh_type    (sh_type),
`ifdef SHIFT_EARLY_EXIT_EN
        .early_exit (early_exit),
`endif
        .sh_out     (sh_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Single-bit shifter as the datapath would implement it.
    always_comb begin
        sh_out = sh_src;
        if (sh_dir == 16'hFFFF) begin
            if (sh_type) sh_out = sh_src >> 1;
            else         sh_out = $signed(sh_src) >>> 1;
        end else if (sh_dir == 16'h0001) begin
            sh_out = sh_src << 1;
        end else begin
            sh_out = sh_src;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: pops the scoreboard whenever done is presented.
    initial begin
        int   busy_run;
        exp_t e;
        busy_run = 0;
        forever begin
            @(negedge clk);
            if (busy) busy_run++;
            else      busy_run = 0;
            if (!reset && done) begin
                if (sb.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_done: got done=1 at cycle %0d expected none", cyc);
                end else begin
                    e = sb.pop_front();
                    check("result",      32'(result),   32'(e.res));
                    check("done_cycle",  32'(cyc),      32'(e.done_cyc));
                    check("busy_cycles", 32'(busy_run), 32'(e.busy_cycles));
                    check("sh_dir_done", 32'(sh_dir),   32'h0);
                end
            end
        end
    end

    task automatic issue(input logic [15:0] s, input logic [4:0] a, input logic t, input logic [15:0] r);
        exp_t e;
        int   n;
        n = a[4] ? (32 - int'(a)) : int'(a);
        @(negedge clk);
        src        = s;
        amount     = a;
        shift_type = t;
        start      = 1'b1;
        e.res         = r;
        e.done_cyc    = cyc + 1 + n;
        e.busy_cycles = n + 1;
        sb.push_back(e);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        while ((busy || sb.size() != 0) && k < 40) begin
            @(negedge clk);
            k++;
        end
        if (busy || sb.size() != 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL timeout: got busy=%0d pending=%0d expected idle", busy, sb.size());
            sb.delete();
        end
    endtask

    initial begin
        cyc = 0; n_cmp = 0; n_err = 0;
        reset = 1'b1; start = 1'b0; src = 16'h0; amount = 5'd0; shift_type = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_busy",   32'(busy),   32'h0);
        check("reset_done",   32'(done),   32'h0);
        check("reset_result", 32'(result), 32'h0);
        check("reset_sh_dir", 32'(sh_dir), 32'h0);

        issue(16'h8001, 5'b11101, 1'b0, 16'hF000);
        wait_idle();
        issue(16'h8001, 5'b11101, 1'b1, 16'h1000);
        wait_idle();

        // A start strobed while busy must not disturb the run in flight.
        issue(16'h00F0, 5'd4, 1'b0, 16'h0F00);
        @(negedge clk);
        src = 16'hFFFF; amount = 5'b11111; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_idle();

        issue(16'h1234, 5'd0, 1'b0, 16'h1234);
        wait_idle();
        issue(16'h8000, 5'b10000, 1'b0, 16'hFFFF);
        wait_idle();
        issue(16'hFFFF, 5'b10000, 1'b1, 16'h0000);
        wait_idle();
        issue(16'h0001, 5'd15, 1'b1, 16'h8000);
        wait_idle();

        // Abort: ignored restart, then reset sampled at the third step.
        issue(16'h0003, 5'd5, 1'b0, 16'h0060);
        @(negedge clk);
        src = 16'hAAAA; amount = 5'd1; start = 1'b1;
        @(negedge clk);
        start = 1'b0; reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        sb.delete();
        check("abort_busy",   32'(busy),   32'h0);
        check("abort_done",   32'(done),   32'h0);
        check("abort_result", 32'(result), 32'h0);
        check("abort_sh_dir", 32'(sh_dir), 32'h0);
        repeat (8) @(negedge clk);
        check("abort_still_idle", 32'(busy), 32'h0);

        issue(16'h0003, 5'd5, 1'b0, 16'h0060);
        wait_idle();
        repeat (2) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
